count_stream_checker: RTL and testbench

//   Receive-side monitor for the free-running 8-bit counter stream and its 2-bit
//   "cc" side output, as produced by the counter/adder producers in this design.

---
 rtl/count_stream_checker_if.sv | 11 +
 rtl/count_stream_checker.sv | 112 +++++++++++
 tb/tb_count_stream_checker.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/count_stream_checker_if.sv
// rtl/count_stream_checker_if.sv - count/cc sample stream carried from producer to checker
interface count_stream_checker_if #(
    parameter int WIDTH = 8
) ();
    logic             valid;
    logic [WIDTH-1:0] count;
    logic [1:0]       cc;

    modport master (output valid, output count, output cc);
    modport slave  (input  valid, input  count, input  cc);
endinterface

// File: rtl/count_stream_checker.sv
// rtl/count_stream_checker.sv - locks onto an incrementing count stream and flags slips; optional cc check under CC_CHECK_EN
module count_stream_checker #(
    parameter int WIDTH    = 8,
    parameter int LOCK_CNT = 4,
    parameter int ERRW     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    count_stream_checker_if.slave stream,
    output logic                  locked,
    output logic                  err_pulse,
    output logic [ERRW-1:0]       err_count,
    output logic [WIDTH-1:0]      expected,
    output logic [1:0]            state
);
    localparam int RW = $clog2(LOCK_CNT + 1);
    localparam logic [RW-1:0] LOCK_RUN = RW'(LOCK_CNT);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        LOCKED = 2'd1,
        SLIP   = 2'd2
    } state_t;

    state_t           st;
    logic [RW-1:0]    run;
    logic             match;
    logic             cc_bad;
    logic             bad;
    logic [RW-1:0]    run_inc;
    logic [WIDTH-1:0] next_count;
    logic [ERRW-1:0]  err_inc;

`ifdef CC_CHECK_EN
    always_comb begin
        cc_bad = (stream.cc != (2'({1'b0, stream.count[0]}) + 2'd1));
    end
`else
    logic unused_cc;
    assign unused_cc = ^stream.cc;
    always_comb begin
        cc_bad = 1'b0;
    end
`endif

    always_comb begin
        match      = (stream.count == expected);
        bad        = !match || cc_bad;
        next_count = stream.count + WIDTH'(1);
        run_inc    = (run == LOCK_RUN) ? run : run + RW'(1);
        err_inc    = (err_count == {ERRW{1'b1}}) ? err_count : err_count + ERRW'(1);
    end

    assign state = st;

    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= SEARCH;
            run       <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
            expected  <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (stream.valid) begin
                // Always resync to the observed value so one slip costs one error.
                expected <= next_count;
                case (st)
                    SEARCH: begin
                        if (match) begin
                            run <= run_inc;
                            if (run_inc == LOCK_RUN) begin
                                st     <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else begin
                            run <= RW'(1);
                        end
                    end
                    LOCKED: begin
                        if (bad) begin
                            err_pulse <= 1'b1;
                            err_count <= err_inc;
                            run       <= RW'(1);
                            st        <= SLIP;
                            locked    <= 1'b0;
                        end
                    end
                    SLIP: begin
                        if (bad) begin
                            err_pulse <= 1'b1;
                            err_count <= err_inc;
                            run       <= RW'(1);
                        end else begin
                            run <= run_inc;
                            if (run_inc == LOCK_RUN) begin
                                st     <= LOCKED;
                                locked <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        st     <= SEARCH;
                        run    <= '0;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_count_stream_checker.sv
// tb/tb_count_stream_checker.sv - scoreboard bench for count_stream_checker with directed and random streams
module tb_count_stream_checker;
    localparam int WIDTH    = 8;
    localparam int LOCK_CNT = 4;
    localparam int ERRW     = 4;
    localparam int MOD      = 1 << WIDTH;
    localparam int ERR_MAX  = (1 << ERRW) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             locked;
    logic             err_pulse;
    logic [ERRW-1:0]  err_count;
    logic [WIDTH-1:0] expected;
    logic [1:0]       state;

    count_stream_checker_if #(.WIDTH(WIDTH)) bus ();

    count_stream_checker #(.WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .ERRW(ERRW)) dut (
        .clk       (clk),
        .rst       (rst),
        .stream    (bus.slave),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .expected  (expected),
        .state     (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int tag;
        int lck;
        int pls;
        int errs;
        int exp_val;
        int st;
    } obs_t;

    obs_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    // Reference: mode 0 hunting, 1 trusted, 2 recovering
    int m_mode, m_streak, m_next, m_errs, m_pulse;
    int cur;
    int tag = 0;

    function automatic void model_reset();
        m_mode = 0; m_streak = 0; m_next = 0; m_errs = 0; m_pulse = 0;
    endfunction

    function automatic void model_sample(int v, int c, int ccv);
        bit good_cc;
        bit in_seq;
        m_pulse = 0;
        if (v == 0) return;
        in_seq  = (c == m_next);
        good_cc = 1'b1;
`ifdef CC_CHECK_EN
        good_cc = (ccv == (c % 2) + 1);
`endif
        if (m_mode == 0) begin
            m_streak = in_seq ? ((m_streak + 1 > LOCK_CNT) ? LOCK_CNT : m_streak + 1) : 1;
            if (m_streak == LOCK_CNT) m_mode = 1;
        end else if (in_seq && good_cc) begin
            if (m_mode == 2) begin
                m_streak = (m_streak + 1 > LOCK_CNT) ? LOCK_CNT : m_streak + 1;
                if (m_streak == LOCK_CNT) m_mode = 1;
            end
        end else begin
            m_pulse  = 1;
            m_errs   = (m_errs < ERR_MAX) ? m_errs + 1 : ERR_MAX;
            m_streak = 1;
            m_mode   = 2;
        end
        m_next = (c + 1) % MOD;
    endfunction

    function automatic void push_exp();
        obs_t o;
        o.tag = tag; o.lck = (m_mode == 1) ? 1 : 0; o.pls = m_pulse;
        o.errs = m_errs; o.exp_val = m_next; o.st = m_mode;
        sb.push_back(o);
        tag++;
    endfunction

    task automatic drive(int r, int v, int c, int ccv);
        @(negedge clk);
        rst       = r[0];
        bus.valid = v[0];
        bus.count = WIDTH'(c);
        bus.cc    = 2'(ccv);
        if (r != 0) model_reset();
        else model_sample(v, c, ccv);
        if (v != 0 && r == 0) cur = (c + 1) % MOD;
        push_exp();
    endtask

    task automatic send(int c);
        drive(0, 1, c, (c % 2) + 1);
    endtask

    task automatic chk(string name, int t, int act, int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s sample %0d: got %0d, expected %0d", name, t, act, req);
        end
    endtask

    initial begin : monitor
        obs_t o;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                o = sb.pop_front();
                chk("locked",    o.tag, int'(locked),    o.lck);
                chk("err_pulse", o.tag, int'(err_pulse), o.pls);
                chk("err_count", o.tag, int'(err_count), o.errs);
                chk("expected",  o.tag, int'(expected),  o.exp_val);
                chk("state",     o.tag, int'(state),     o.st);
            end
        end
    end

    initial begin : driver
        int r, v, c, ccv;
        rst = 1'b1; bus.valid = 1'b0; bus.count = '0; bus.cc = '0;
        model_reset();
        cur = 0;
        drive(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 0);
        for (int i = 10; i <= 13; i++) send(i);
        send(14); send(15); send(17);
        drive(0, 0, 0, 0);
        send(18); send(19); send(20);
        send(250); send(251); send(252); send(253);
        send(254); send(255); send(0); send(1);
        drive(0, 1, 2, 2);
        drive(0, 1, 40, 2);
        send(50);
        drive(1, 1, 51, 2);
        drive(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) send(100 + i);
        for (int i = 0; i < ERR_MAX + 4; i++) send(0);
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 99) < 2) ? 1 : 0;
            v   = ($urandom_range(0, 99) < 15) ? 0 : 1;
            c   = ($urandom_range(0, 99) < 85) ? cur : int'($urandom_range(0, MOD - 1));
            ccv = ($urandom_range(0, 99) < 90) ? (c % 2) + 1 : int'($urandom_range(0, 3));
            drive(r, v, c, ccv);
        end
        drive(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d samples unchecked, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
